// File: rtl/mcu_pkg.sv
// Shared MCU command constants for the outbound command queue.
// Command words are {cmd[7:0], addr/data[15:0]}.
package mcu_pkg;

   localparam int CMD_W = 24;

   localparam logic [7:0] CMD_NOPE       = 8'hFF;
   localparam logic [7:0] CMD_USB_UART   = 8'hFC;
   localparam logic [7:0] CMD_ESP_UART   = 8'hFB;
   localparam logic [7:0] CMD_RTC        = 8'hFA;
   localparam logic [7:0] CMD_FLASH      = 8'hF9;
   localparam logic [7:0] CMD_DEBUG_ADDR = 8'hF8;
   localparam logic [7:0] CMD_DEBUG_DATA = 8'hF7;

   localparam logic [CMD_W-1:0] NOPE_WORD = {CMD_NOPE, 16'h0000};

   typedef enum logic [1:0] {
      SEL_IDLE,
      SEL_SRC0,
      SEL_RR,
      SEL_NOPE
   } sel_e;

endpackage

// File: rtl/mcu_queue_arbiter_rr_pick.sv
// Combinational round-robin encoder over sources 1..N-1.
// Search starts after last and wraps from N-1 back to 1.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   last,
   output logic [2:0]   idx,
   output logic         found
);

   always_comb begin
      int c;
      c     = 0;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 1; k < N; k++) begin
         c = int'(last) + k;
         if (c >= N) c = c - (N - 1);
         if (!found && req[c]) begin
            found = 1'b1;
            idx   = 3'(c);
         end
      end
   end

endmodule

// File: rtl/mcu_queue_arbiter.sv
// Valid/ready scheduler feeding the MCU outbound command FIFO:
// source 0 priority, round-robin for the rest, starvation guard, NOPE fill.
module mcu_queue_arbiter
   import mcu_pkg::*;
#(
   parameter int               N_REQ        = 4,
   parameter logic [N_REQ-1:0] BUSY_MASK    = N_REQ'(1),
   parameter int               STARVE_LIMIT = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [CMD_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   mcu_busy,
   input  logic                   nope_en,
   input  logic                   q_full,
   input  logic                   q_empty,
   output logic                   q_wr,
   output logic [CMD_W-1:0]       q_di,
   output logic [2:0]             grant_id,
   output logic                   grant_nope
);

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   logic [N_REQ-1:0] req_ready_q, req_ready_d;
   logic             q_wr_q, q_wr_d;
   logic [CMD_W-1:0] q_di_q, q_di_d;
   logic [2:0]       grant_id_q, grant_id_d;
   logic             grant_nope_q, grant_nope_d;
   logic [3:0]       starve_q, starve_d;
   logic [2:0]       rr_last_q, rr_last_d;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] rr_req;
   logic [2:0]       rr_idx;
   logic             rr_found;
   logic             slot;
   logic [2:0]       gnt_idx;
   sel_e             sel;

   // A source already holding ready must not be granted again
   assign elig   = req_valid & ~req_ready_q
                 & ({N_REQ{~mcu_busy}} | BUSY_MASK);
   assign rr_req = {elig[N_REQ-1:1], 1'b0};
   assign slot   = ~q_full & ~q_wr_q;

   rr_pick #(.N(N_REQ)) u_rr (
      .req   (rr_req),
      .last  (rr_last_q),
      .idx   (rr_idx),
      .found (rr_found)
   );

   always_comb begin
      sel = SEL_IDLE;
      if (slot) begin
         if (starve_q == LIM && rr_found) sel = SEL_RR;
         else if (elig[0])                sel = SEL_SRC0;
         else if (rr_found)               sel = SEL_RR;
         else if (q_empty && nope_en)     sel = SEL_NOPE;
      end
   end

   always_comb begin
      req_ready_d  = '0;
      q_wr_d       = 1'b0;
      q_di_d       = q_di_q;
      grant_id_d   = grant_id_q;
      grant_nope_d = 1'b0;
      starve_d     = starve_q;
      rr_last_d    = rr_last_q;
      gnt_idx      = (sel == SEL_RR) ? rr_idx : 3'd0;

      unique case (sel)
         SEL_SRC0, SEL_RR: begin
            q_wr_d               = 1'b1;
            q_di_d               = req_data[int'(gnt_idx)*CMD_W +: CMD_W];
            req_ready_d[gnt_idx] = 1'b1;
            grant_id_d           = gnt_idx;
         end
         SEL_NOPE: begin
            q_wr_d       = 1'b1;
            q_di_d       = NOPE_WORD;
            grant_nope_d = 1'b1;
         end
         default: ;
      endcase

      if (sel == SEL_RR) begin
         rr_last_d = rr_idx;
         starve_d  = 4'd0;
      end else if (sel == SEL_SRC0 && rr_found && starve_q != LIM) begin
         starve_d = starve_q + 4'd1;
      end
      if (!rr_found) starve_d = 4'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ready_q  <= '0;
         q_wr_q       <= 1'b0;
         q_di_q       <= '0;
         grant_id_q   <= 3'd0;
         grant_nope_q <= 1'b0;
         starve_q     <= 4'd0;
         rr_last_q    <= 3'(N_REQ - 1);
      end else begin
         req_ready_q  <= req_ready_d;
         q_wr_q       <= q_wr_d;
         q_di_q       <= q_di_d;
         grant_id_q   <= grant_id_d;
         grant_nope_q <= grant_nope_d;
         starve_q     <= starve_d;
         rr_last_q    <= rr_last_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign q_wr       = q_wr_q;
   assign q_di       = q_di_q;
   assign grant_id   = grant_id_q;
   assign grant_nope = grant_nope_q;

endmodule

// File: tb/tb_mcu_queue_arbiter.sv
// Bench for mcu_queue_arbiter: directed scenarios plus random traffic
// checked against a behavioural scheduler model.
module tb_mcu_queue_arbiter;

   localparam int N   = 4;
   localparam int LIM = 8;
   localparam logic [3:0] BMASK = 4'b0001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  valid = '0;
   logic [95:0] data = '0;
   logic [3:0]  req_ready;
   logic        mcu_busy = 1'b0;
   logic        nope_en = 1'b0;
   logic        q_full = 1'b0;
   logic        q_empty = 1'b0;
   logic        q_wr;
   logic [23:0] q_di;
   logic [2:0]  grant_id;
   logic        grant_nope;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit        m_wr, m_gnope;
   bit [23:0] m_di;
   bit [3:0]  m_rdy;
   int        m_gid, m_starve, m_last;

   int dut_log[$];
   int nope_cnt;

   always #5 clk = ~clk;

   mcu_queue_arbiter #(
      .N_REQ(N), .BUSY_MASK(BMASK), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(valid), .req_data(data), .req_ready(req_ready),
      .mcu_busy(mcu_busy), .nope_en(nope_en),
      .q_full(q_full), .q_empty(q_empty),
      .q_wr(q_wr), .q_di(q_di),
      .grant_id(grant_id), .grant_nope(grant_nope)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_next(input int last, input bit [3:0] e);
      for (int k = 1; k < N; k++) begin
         int c;
         c = 1 + ((last - 1 + k) % (N - 1));
         if (e[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_wr = 0; m_gnope = 0; m_di = '0; m_rdy = '0;
      m_gid = 0; m_starve = 0; m_last = N - 1;
   endtask

   // one clock: model predicts, DUT is sampled 1 time unit after the edge
   task automatic tick();
      bit [3:0] e;
      bit       any_rr;
      int       pick, g;
      bit       n_wr, n_gn;
      bit [23:0] n_di;
      bit [3:0] n_rdy;
      int       n_gid, n_st, n_last;
      for (int i = 0; i < N; i++)
         e[i] = valid[i] && !m_rdy[i] && (!mcu_busy || BMASK[i]);
      any_rr = |e[3:1];
      pick   = rr_next(m_last, e);
      n_wr = 0; n_gn = 0; n_di = m_di; n_rdy = '0;
      n_gid = m_gid; n_st = m_starve; n_last = m_last;
      g = -1;
      if (!q_full && !m_wr) begin
         if (m_starve == LIM && any_rr) g = pick;
         else if (e[0]) g = 0;
         else if (any_rr) g = pick;
         else if (q_empty && nope_en) begin
            n_wr = 1; n_gn = 1; n_di = 24'hFF0000;
         end
      end
      if (g >= 0) begin
         n_wr = 1; n_di = data[g*24 +: 24]; n_rdy[g] = 1; n_gid = g;
         if (g == 0) begin
            if (any_rr && m_starve < LIM) n_st = m_starve + 1;
         end else begin
            n_st = 0; n_last = g;
         end
      end
      if (!any_rr) n_st = 0;
      @(posedge clk);
      #1;
      m_wr = n_wr; m_gnope = n_gn; m_di = n_di; m_rdy = n_rdy;
      m_gid = n_gid; m_starve = n_st; m_last = n_last;
      chk("q_wr", 32'(q_wr), 32'(m_wr));
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      chk("grant_nope", 32'(grant_nope), 32'(m_gnope));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      if (m_wr) chk("q_di", 32'(q_di), 32'(m_di));
      if (q_wr === 1'b1) begin
         dut_log.push_back(int'(grant_id));
         if (grant_nope === 1'b1) nope_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_q_wr", 32'(q_wr), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_q_di", 32'(q_di), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_gnope", 32'(grant_nope), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      dut_log.delete();
      nope_cnt = 0;
   endtask

   initial begin
      int exp_seq[$];
      model_reset();
      nope_cnt = 0;
      @(negedge clk);
      do_reset();

      // single source 1
      valid[1] = 1'b1;
      data[24 +: 24] = 24'hFC0041;
      tick();
      chk("t1_q_wr", 32'(q_wr), 32'd1);
      chk("t1_q_di", 32'(q_di), 32'h00FC0041);
      chk("t1_ready", 32'(req_ready), 32'b0010);
      tick();
      chk("t1_no_dup", 32'(q_wr), 32'd0);
      valid = '0;
      tick();

      // round-robin 1,2,3
      do_reset();
      valid = 4'b1110;
      data[24 +: 24] = 24'hFC0001;
      data[48 +: 24] = 24'hFB0002;
      data[72 +: 24] = 24'hFA0003;
      repeat (12) tick();
      exp_seq = '{1, 2, 3, 1, 2, 3};
      chk("rr_count", 32'(dut_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < dut_log.size(); i++)
         chk("rr_seq", 32'(dut_log[i]), 32'(exp_seq[i]));
      valid = '0;

      // starvation guard with sources 0 and 2
      do_reset();
      valid = 4'b0101;
      data[0 +: 24] = 24'hF80010;
      repeat (36) tick();
      exp_seq.delete();
      repeat (2) begin
         repeat (LIM) exp_seq.push_back(0);
         exp_seq.push_back(2);
      end
      chk("starve_count", 32'(dut_log.size()), 32'd18);
      for (int i = 0; i < 18 && i < dut_log.size(); i++)
         chk("starve_seq", 32'(dut_log[i]), 32'(exp_seq[i]));
      valid = '0;

      // mcu_busy masks source 3
      do_reset();
      mcu_busy = 1'b1;
      valid[3] = 1'b1;
      data[72 +: 24] = 24'hFA0512;
      repeat (6) tick();
      chk("busy_nowr", 32'(dut_log.size()), 32'd0);
      mcu_busy = 1'b0;
      tick();
      chk("busy_rel_wr", 32'(q_wr), 32'd1);
      chk("busy_rel_di", 32'(q_di), 32'h00FA0512);
      chk("busy_rel_gid", 32'(grant_id), 32'd3);
      valid = '0;
      tick();

      // NOPE fill, then blocked by q_full
      dut_log.delete();
      nope_cnt = 0;
      q_empty = 1'b1;
      nope_en = 1'b1;
      tick();
      chk("nope_di", 32'(q_di), 32'h00FF0000);
      chk("nope_flag", 32'(grant_nope), 32'd1);
      chk("nope_gid", 32'(grant_id), 32'd3);
      repeat (5) tick();
      chk("nope_cnt", 32'(nope_cnt), 32'd3);
      q_full = 1'b1;
      tick();
      dut_log.delete();
      repeat (4) tick();
      chk("full_nowr", 32'(dut_log.size()), 32'd0);
      q_full = 1'b0;
      nope_en = 1'b0;
      q_empty = 1'b0;
      tick();

      // reset mid-operation drops in-flight ready
      do_reset();
      valid[1] = 1'b1;
      data[24 +: 24] = 24'hFC0077;
      tick();
      chk("pre_rst_wr", 32'(q_wr), 32'd1);
      do_reset();
      tick();
      chk("regrant_wr", 32'(q_wr), 32'd1);
      chk("regrant_gid", 32'(grant_id), 32'd1);
      chk("regrant_di", 32'(q_di), 32'h00FC0077);
      valid = '0;
      tick();

      // random traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (m_rdy[i]) begin
               if ($urandom_range(1, 0) == 0) valid[i] = 1'b0;
               else data[i*24 +: 24] = 24'($urandom);
            end else if (!valid[i]) begin
               if ($urandom_range(9, 0) < 3) begin
                  valid[i] = 1'b1;
                  data[i*24 +: 24] = 24'($urandom);
               end
            end else if ($urandom_range(19, 0) == 0) begin
               valid[i] = 1'b0;
            end
         end
         if ($urandom_range(15, 0) == 0) mcu_busy = ~mcu_busy;
         q_full  = ($urandom_range(5, 0) == 0);
         q_empty = ($urandom_range(1, 0) == 0);
         nope_en = ($urandom_range(2, 0) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcu_queue_arbiter.md
# mcu_queue_arbiter

Arbitrates 24-bit command words from several FPGA-side producers (USB UART, ESP UART, RTC, flash bridge, debug) onto the single write port of the MCU outbound command FIFO. It replaces the fixed if/else priority chain with a valid/ready scheduler that provides:
- strict priority for source 0;
- round-robin among the other sources, with a starvation guard;
- gating of selected sources while the MCU is initialising;
- NOPE fill when the queue runs dry.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- BUSY_MASK, 4'b0001: bit i=1 means source i may be granted while mcu_busy=1.
- STARVE_LIMIT, 8: consecutive source-0 grants allowed while another source waits.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-source request; data must be held stable until accepted.
- req_data  in  24*N_REQ  flattened {cmd,addr,data}; source i occupies bits [24i+23:24i].
- req_ready  out  N_REQ  one-cycle accept pulse per source.
- mcu_busy  in  1  MCU init in progress.
- nope_en  in  1  enables NOPE fill.
- q_full  in  1  FIFO full.
- q_empty  in  1  FIFO empty.
- q_wr  out  1  FIFO write strobe.
- q_di  out  24  FIFO write data.
- grant_id  out  3  index of the last granted source.
- grant_nope  out  1  high with q_wr when the written word is NOPE.

## Operation
- **Eligible source i:** all of the following hold:
  - req_valid[i]=1;
  - req_ready[i]=0 in the current cycle, so the same request is never granted twice;
  - ~mcu_busy or BUSY_MASK[i].
- **Issue slot:** a cycle where q_full=0 and q_wr=0. At most one FIFO write occurs per two cycles, so q_full is always current.
- **Selection, in order, per issue slot:**
  1. If starve_cnt==STARVE_LIMIT and any source 1..N_REQ-1 is eligible, grant by round-robin among 1..N_REQ-1.
  2. Otherwise, if source 0 is eligible, grant source 0.
  3. Otherwise, grant by round-robin among 1..N_REQ-1.
  4. Otherwise, if q_empty and nope_en, write NOPE = {CMD_NOPE, 16'h0000}.
  5. Otherwise, idle.
- **Round-robin:** search starts at rr_last+1 and wraps from N_REQ-1 to 1, skipping 0. rr_last updates to the granted index on every round-robin grant.
- **starve_cnt** (4-bit, saturating at STARVE_LIMIT):
  - increments on a source-0 grant while any source 1..N_REQ-1 is eligible;
  - clears on any round-robin grant;
  - clears in any cycle with no eligible source 1..N_REQ-1.
- **On grant of source i:** q_di<=req_data[i], q_wr<=1, req_ready[i]<=1, grant_id<=i, grant_nope<=0.
- **On NOPE:** q_di<=NOPE, q_wr<=1, grant_nope<=1, req_ready=0, grant_id unchanged. NOPE ignores mcu_busy.
- **Requester protocol:** the transfer completes on the edge at which req_ready[i] rises. The requester either drops valid or presents new data in the cycle req_ready[i] is seen high. Withdrawing valid before ready is allowed and causes no write.
- **Reset values:**
  - q_wr=0, q_di=0, req_ready=0, grant_id=0, grant_nope=0;
  - starve_cnt=0;
  - rr_last=N_REQ-1, so the first round-robin grant goes to source 1.

## Timing
- Latency from req_valid rising (slot free, no contention) to q_wr/req_ready: 1 clk. Both are registered and asserted in the same cycle.
- Peak throughput: one word per 2 clk. A single source is limited to one word per 2 clk.
- q_full rising during the cycle q_wr=1 has no effect on that write. The FIFO accepted it at the previous-slot check.
- mcu_busy is sampled at the issue slot only. Deasserting it makes masked sources eligible at the next slot.
- Reset asserted mid-operation: outputs clear immediately (asynchronously), and any in-flight ready is lost. Requesters still holding valid are regranted after reset release, in order from source 0.
- Source 0 with valid held continuously and source 2 valid, STARVE_LIMIT=8: 8 source-0 grants, then 1 source-2 grant, then the pattern repeats.

## Structure
- Shared package mcu_pkg:
  - CMD_* 8-bit command constants (CMD_NOPE=8'hFF, CMD_USB_UART=8'hFC, CMD_ESP_UART=8'hFB, CMD_RTC=8'hFA, CMD_FLASH=8'hF9, CMD_DEBUG_ADDR/DATA);
  - the 24-bit command-word width constant;
  - NOPE word constant.
- Sub-module rr_pick: combinational round-robin encoder. Takes a request vector and last index; outputs grant index and found flag. One instance covers sources 1..N_REQ-1.

## Test plan
- Single source 1 sends 24'hFC0041, FIFO not full → q_wr=1, q_di=24'hFC0041, req_ready[1]=1 one cycle later; no second write while valid is still high during the ready cycle.
- Sources 1, 2 and 3 valid continuously → grant_id sequence 1,2,3,1,2,3 at 2-clk spacing.
- Source 0 and source 2 valid continuously, STARVE_LIMIT=8 → 8 writes from source 0, 1 from source 2, repeating; starve_cnt never exceeds 8.
- mcu_busy=1, BUSY_MASK=4'b0001, source 3 valid (RTC 24'hFA0512) → no write for source 3; drop mcu_busy → write 24'hFA0512 at the next slot.
- No requests, q_empty=1, nope_en=1 → q_di=24'hFF0000 with grant_nope=1 every 2 clk; q_full=1 → q_wr stays 0.
- Reset asserted the cycle after q_wr → q_wr and req_ready clear immediately; after release, source 1 (still valid) is regranted within 1 clk.
